posit_encoder: RTL



---
 rtl/posit_pkg.sv | 40 ++++
 rtl/DSR_right_N_S.sv | 22 ++
 rtl/posit_round.sv | 42 ++++
 rtl/posit_encoder.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/posit_pkg.sv
// Shared posit definitions: width helpers, special-pattern constant functions
// and the unpacked-value record exchanged between posit pipeline blocks.
package posit_pkg;

  function automatic int log2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < value) r = r + 1;
    end
    return r;
  endfunction

  localparam int POSIT_N  = 8;
  localparam int POSIT_ES = 4;
  localparam int POSIT_FW = 8;
  localparam int POSIT_BS = log2(POSIT_N);
  localparam int POSIT_SW = POSIT_ES + POSIT_BS + 2;

  function automatic logic [63:0] posit_maxpos(input int n);
    return (64'd1 << (n - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] posit_minpos(input int n);
    return (n > 1) ? 64'd1 : 64'd0;
  endfunction

  function automatic logic [63:0] posit_nar(input int n);
    return 64'd1 << (n - 1);
  endfunction

  typedef struct packed {
    logic                sign;
    logic [POSIT_SW-1:0] scale;
    logic [POSIT_FW-1:0] frac;
    logic                zero;
    logic                inf;
  } posit_unpacked_t;

endpackage

// File: rtl/DSR_right_N_S.sv
// Logarithmic dynamic right shifter: c = a >> b, zero fill, one mux rank per
// bit of the shift amount.
module DSR_right_N_S #(
  parameter int N = 16,
  parameter int S = 4
) (
  input  logic [N-1:0] a,
  input  logic [S-1:0] b,
  output logic [N-1:0] c
);

  logic [N-1:0] stage [S+1];

  assign stage[0] = a;

  for (genvar i = 0; i < S; i++) begin : g_stage
    assign stage[i+1] = b[i] ? (stage[i] >> (1 << i)) : stage[i];
  end

  assign c = stage[S];

endmodule

// File: rtl/posit_round.sv
// Magnitude rounding and clamping for the posit packer. Round-to-nearest-even
// is built only when POSIT_ENCODER_ROUND_EN is defined; otherwise truncation.
module posit_round
  import posit_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-2:0] mag,
  input  logic         guard,
  input  logic         sticky,
  input  logic         sat_hi,
  input  logic         sat_lo,
  output logic [N-2:0] mag_rnd
);

  localparam logic [N-1:0] MAXPOS = N'(posit_maxpos(N));
  localparam logic [N-1:0] MINPOS = N'(posit_minpos(N));

  logic [N-1:0] sum;

`ifdef POSIT_ENCODER_ROUND_EN
  logic inc;
  assign inc = guard & (sticky | mag[0]);
  assign sum = {1'b0, mag} + {{(N-1){1'b0}}, inc};
`else
  logic unused_round_bits;
  assign unused_round_bits = guard ^ sticky;
  assign sum = {1'b0, mag};
`endif

  // A carry out means we rounded past maxpos; a nonzero value never packs to 0.
  always_comb begin
    mag_rnd = sum[N-2:0];
    if (sum[N-1]) mag_rnd = MAXPOS[N-2:0];
    if (sat_hi) begin
      mag_rnd = MAXPOS[N-2:0];
    end else if (sat_lo || (mag_rnd == '0)) begin
      mag_rnd = MINPOS[N-2:0];
    end
  end

endmodule

// File: rtl/posit_encoder.sv
// Three-stage valid/ready posit packer: unpacked (sign, scale, frac) -> N-bit
// posit. Rounding mode selected by POSIT_ENCODER_ROUND_EN (see posit_round).
module posit_encoder
  import posit_pkg::*;
#(
  parameter int N  = 8,
  parameter int es = 4,
  parameter int FW = 8,
  parameter int SW = es + log2(N) + 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_sign,
  input  logic [SW-1:0] in_scale,
  input  logic [FW-1:0] in_frac,
  input  logic          in_zero,
  input  logic          in_inf,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_posit,
  output logic          out_zero,
  output logic          out_inf
);

  localparam int KW  = SW - es;
  localparam int BW  = N + es + FW;
  localparam int S   = log2(N) + 1;
  localparam int PAD = BW - 1 - es - FW;
  localparam logic [N-1:0] NAR = N'(posit_nar(N));

  logic adv;
  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  // Upper scale bits are already floor(scale / 2^es) in two's complement.
  logic signed [KW-1:0] k_in;
  logic                 sat_hi_in;
  logic                 sat_lo_in;

  assign k_in      = $signed(in_scale[SW-1:es]);
  assign sat_hi_in = int'(k_in) >= (N - 2);
  assign sat_lo_in = int'(k_in) <= -(N - 2);

  logic                 s1_valid;
  logic                 s1_sign;
  logic signed [KW-1:0] s1_k;
  logic [es-1:0]        s1_e;
  logic [FW-1:0]        s1_frac;
  logic                 s1_zero;
  logic                 s1_inf;
  logic                 s1_sat_hi;
  logic                 s1_sat_lo;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_sign   <= 1'b0;
      s1_k      <= '0;
      s1_e      <= '0;
      s1_frac   <= '0;
      s1_zero   <= 1'b0;
      s1_inf    <= 1'b0;
      s1_sat_hi <= 1'b0;
      s1_sat_lo <= 1'b0;
    end else if (adv) begin
      s1_valid  <= in_valid;
      s1_sign   <= in_sign;
      s1_k      <= k_in;
      s1_e      <= in_scale[es-1:0];
      s1_frac   <= in_frac;
      s1_zero   <= in_zero;
      s1_inf    <= in_inf;
      s1_sat_hi <= sat_hi_in;
      s1_sat_lo <= sat_lo_in;
    end
  end

  // The regime run is produced by shifting in copies of the run bit; the
  // terminating bit travels at the head of the body.
  int            k_s1;
  int            run_len;
  logic          run_ones;
  logic [S-1:0]  shamt;

  always_comb begin
    k_s1     = int'(s1_k);
    run_ones = (k_s1 >= 0);
    run_len  = run_ones ? (k_s1 + 1) : -k_s1;
    if (run_len > N - 1) run_len = N - 1;
    shamt    = S'(run_len);
  end

  logic [BW-1:0] body_raw;
  logic [BW-1:0] shift_in;
  logic [BW-1:0] shift_out;
  logic [BW-1:0] body;

  assign body_raw = {~run_ones, s1_e, s1_frac, {PAD{1'b0}}};
  assign shift_in = run_ones ? ~body_raw : body_raw;

  DSR_right_N_S #(
    .N(BW),
    .S(S)
  ) u_body_shift (
    .a(shift_in),
    .b(shamt),
    .c(shift_out)
  );

  assign body = run_ones ? ~shift_out : shift_out;

  logic [N-2:0] mag_raw;
  logic         guard;
  logic         sticky;
  logic [N-2:0] mag_rnd;

  assign mag_raw = body[BW-1 -: N-1];
  assign guard   = body[BW-N];
  assign sticky  = |body[BW-N-1:0];

  posit_round #(
    .N(N)
  ) u_round (
    .mag    (mag_raw),
    .guard  (guard),
    .sticky (sticky),
    .sat_hi (s1_sat_hi),
    .sat_lo (s1_sat_lo),
    .mag_rnd(mag_rnd)
  );

  logic         s2_valid;
  logic         s2_sign;
  logic         s2_zero;
  logic         s2_inf;
  logic [N-2:0] s2_mag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_sign  <= 1'b0;
      s2_zero  <= 1'b0;
      s2_inf   <= 1'b0;
      s2_mag   <= '0;
    end else if (adv) begin
      s2_valid <= s1_valid;
      s2_sign  <= s1_sign;
      s2_zero  <= s1_zero;
      s2_inf   <= s1_inf;
      s2_mag   <= mag_rnd;
    end
  end

  logic [N-1:0] posit_next;
  logic [N-1:0] pos_mag;

  always_comb begin
    pos_mag    = {1'b0, s2_mag};
    posit_next = s2_sign ? -pos_mag : pos_mag;
    if (s2_inf) begin
      posit_next = NAR;
    end else if (s2_zero) begin
      posit_next = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_posit <= '0;
      out_zero  <= 1'b0;
      out_inf   <= 1'b0;
    end else if (adv) begin
      out_valid <= s2_valid;
      out_posit <= posit_next;
      out_zero  <= s2_zero & ~s2_inf;
      out_inf   <= s2_inf;
    end
  end

endmodule
